// File: rtl/reflet_float_mant_mult_seq_if.sv
// Start/done handshake and operand/product bus for the sequential mantissa multiplier.
interface reflet_float_mant_mult_seq_if #(
    parameter int unsigned size = 24
);
    logic              start;
    logic [size-1:0]   in1;
    logic [size-1:0]   in2;
    logic              busy;
    logic              done;
    logic [2*size-1:0] product;

    modport master (output start, in1, in2, input busy, done, product);
    modport slave  (input start, in1, in2, output busy, done, product);
endinterface

// File: rtl/reflet_float_mant_mult_seq.sv
// Radix-2 shift-and-add unsigned multiplier: one partial product per clock,
// full 2*size-bit product, start/done handshake.
module reflet_float_mant_mult_seq #(
    parameter int unsigned size = 24
) (
    input logic                            clk,
    input logic                            reset,
    reflet_float_mant_mult_seq_if.slave    bus
);
    localparam int unsigned PW = 2 * size;
    localparam int unsigned CW = (size > 1) ? $clog2(size) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   mcand;
    logic [size-1:0] mplier;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   sum;
    logic [CW-1:0]   count;
    logic            busy;
    logic            done;
    logic [PW-1:0]   product;

    // The multiplicand shifts left each step, so it is always aligned to bit position count.
    always_comb begin
        sum = acc;
        if (mplier[0]) sum = acc + mcand;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        mcand  <= PW'(bus.in1);
                        mplier <= bus.in2;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (count == CW'(size - 1)) begin
                        product <= sum;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        acc   <= sum;
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;
endmodule

// File: tb/tb_reflet_float_mant_mult_seq.sv
// Self-checking bench: directed cases, back-to-back starts, reset abort,
// random pairs at size=24 and exhaustive pairs at size=4.
module tb_reflet_float_mant_mult_seq;
    logic clk = 1'b0;
    logic reset;
    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    reflet_float_mant_mult_seq_if #(.size(24)) m24 ();
    reflet_float_mant_mult_seq_if #(.size(4))  m4 ();

    reflet_float_mant_mult_seq #(.size(24)) dut24 (.clk(clk), .reset(reset), .bus(m24.slave));
    reflet_float_mant_mult_seq #(.size(4))  dut4  (.clk(clk), .reset(reset), .bus(m4.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction on the 24-bit unit; operands are scrambled after capture.
    task automatic mul24(input logic [23:0] a, input logic [23:0] b, input bit full);
        logic [63:0] exp;
        logic [47:0] prev;
        int unsigned cyc;
        int unsigned busy_cnt;
        bit stable;
        exp = 64'(a) * 64'(b);
        @(negedge clk);
        prev = m24.product;
        m24.in1 = a; m24.in2 = b; m24.start = 1'b1;
        @(negedge clk);
        m24.start = 1'b0;
        m24.in1 = 24'($urandom); m24.in2 = 24'($urandom);
        cyc = 0; busy_cnt = 0; stable = 1'b1;
        while (!m24.done && cyc < 100) begin
            if (m24.busy) busy_cnt++;
            if (m24.product !== prev) stable = 1'b0;
            m24.start = 1'(cyc % 3 == 0);
            @(negedge clk);
            cyc++;
        end
        m24.start = 1'b0;
        check("prod24", 64'(m24.product), exp);
        if (full) begin
            check("lat24", 64'(cyc), 64'd24);
            check("busy24", 64'(busy_cnt), 64'd24);
            check("hold24", 64'(stable), 64'd1);
            check("busy_in_done", 64'(m24.busy), 64'd0);
            @(negedge clk);
            check("done_pulse", 64'(m24.done), 64'd0);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic mul4(input logic [3:0] a, input logic [3:0] b);
        int unsigned cyc;
        @(negedge clk);
        m4.in1 = a; m4.in2 = b; m4.start = 1'b1;
        @(negedge clk);
        m4.start = 1'b0; m4.in1 = ~a; m4.in2 = ~b;
        cyc = 0;
        while (!m4.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("prod4", 64'(m4.product), 64'(a) * 64'(b));
        if (cyc != 4) check("lat4", 64'(cyc), 64'd4);
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] op1 [0:79];
        logic [23:0] op2 [0:79];
        int unsigned results;
        int unsigned j;
        bit seen;

        reset = 1'b1;
        m24.start = 1'b0; m24.in1 = '0; m24.in2 = '0;
        m4.start = 1'b0;  m4.in1 = '0;  m4.in2 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(m24.busy), 64'd0);
        check("rst_done", 64'(m24.done), 64'd0);
        check("rst_prod", 64'(m24.product), 64'd0);
        check("rst_prod4", 64'(m4.product), 64'd0);
        reset = 1'b0;

        mul24(24'h800000, 24'h800000, 1'b1);
        check("prod_0x4000", 64'(m24.product), 64'h400000000000);
        mul24(24'hFFFFFF, 24'hFFFFFF, 1'b1);
        check("prod_max", 64'(m24.product), 64'hFFFFFE000001);
        mul24(24'h800000, 24'h800000, 1'b1);
        mul24(24'h000000, 24'hABCDEF, 1'b1);
        mul24(24'h000001, 24'hABCDEF, 1'b1);

        // start held high: captures at cycles 0, 26, 52; done seen 25 cycles after each.
        results = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (m24.done) begin
                j = results * 26;
                check("b2b_time", 64'(n), 64'(j + 25));
                check("b2b_prod", 64'(m24.product), 64'(op1[j]) * 64'(op2[j]));
                results++;
            end
            op1[n] = 24'($urandom); op2[n] = 24'($urandom);
            m24.in1 = op1[n]; m24.in2 = op2[n]; m24.start = 1'b1;
        end
        m24.start = 1'b0;
        check("b2b_count", 64'(results), 64'd3);
        repeat (30) @(negedge clk);

        // Reset at RUN cycle 10 aborts with no done pulse.
        mul24(24'h123456, 24'h654321, 1'b1);
        @(negedge clk);
        m24.in1 = 24'hFFFFFF; m24.in2 = 24'h000003; m24.start = 1'b1;
        @(negedge clk);
        m24.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_pre", 64'(m24.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(m24.busy), 64'd0);
        check("abort_done", 64'(m24.done), 64'd0);
        check("abort_prod", 64'(m24.product), 64'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (m24.done || m24.busy) seen = 1'b1;
        end
        check("abort_quiet", 64'(seen), 64'd0);
        mul24(24'hC0FFEE, 24'h00BEEF, 1'b1);

        for (int k = 0; k < 300; k++)
            mul24(24'($urandom), 24'($urandom), 1'b0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                mul4(4'(a), 4'(b));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
